// File: rtl/multi_mode_shifter.sv
// multi_mode_shifter
// N-bit shift register for an accumulator datapath. A start/busy/done
// handshake launches either a parallel load or a multi-bit shift that
// advances one bit per clock. Supported modes: logical left/right,
// arithmetic right, and rotate left/right. cout holds the last bit that
// left the register, and zero flags an all-zero register.

module multi_mode_shifter #(
    parameter int N   = 8,
    parameter int SHW = 3
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           set,
    input  logic           start,
    input  logic [2:0]     op,
    input  logic [SHW-1:0] num_shift,
    input  logic           Ls,
    input  logic           Rs,
    input  logic [N-1:0]   Reg_in,
    output logic [N-1:0]   Reg_out,
    output logic           busy,
    output logic           done,
    output logic           cout,
    output logic           zero
);

    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_SHL   = 3'b010;
    localparam logic [2:0] OP_SHR   = 3'b011;
    localparam logic [2:0] OP_SAR   = 3'b100;
    localparam logic [2:0] OP_ROL   = 3'b101;
    localparam logic [2:0] OP_ROR   = 3'b110;
    localparam logic [2:0] OP_HOLD2 = 3'b111;

    localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};
    localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // True for the five opcodes that move bits; hold and load are excluded.
    function automatic logic is_shift_op(input logic [2:0] code);
        logic res;
        case (code)
            OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR: res = 1'b1;
            OP_HOLD, OP_LOAD, OP_HOLD2:             res = 1'b0;
            default:                                res = 1'b0;
        endcase
        return res;
    endfunction

    // Performs one single-bit step and returns {outgoing bit, new register value}.
    function automatic logic [N:0] shift_step(
        input logic [2:0]   mode,
        input logic [N-1:0] r,
        input logic         ls,
        input logic         rs
    );
        logic [N:0] res;
        case (mode)
            OP_SHL:  res = {r[N-1], r[N-2:0], ls};
            OP_SHR:  res = {r[0], rs, r[N-1:1]};
            OP_SAR:  res = {r[0], r[N-1], r[N-1:1]};
            OP_ROL:  res = {r[N-1], r[N-2:0], r[N-1]};
            OP_ROR:  res = {r[0], r[0], r[N-1:1]};
            default: res = {1'b0, r};
        endcase
        return res;
    endfunction

    state_t         state_r;
    state_t         state_nxt_s;
    logic [N-1:0]   reg_r;
    logic [N-1:0]   reg_nxt_s;
    logic           cout_r;
    logic           cout_nxt_s;
    logic           busy_r;
    logic           busy_nxt_s;
    logic           done_r;
    logic           done_nxt_s;
    logic [SHW-1:0] cnt_r;
    logic [SHW-1:0] cnt_nxt_s;
    logic [2:0]     op_r;
    logic [2:0]     op_nxt_s;
    logic           ls_r;
    logic           ls_nxt_s;
    logic           rs_r;
    logic           rs_nxt_s;
    logic [N:0]     step_s;
    logic           accept_shift_s;
    logic           last_step_s;

    // A shift with a non-zero count is the only request that needs the SHIFT state.
    assign accept_shift_s = start && is_shift_op(op) && (num_shift != CNT_ZERO);
    assign last_step_s    = (cnt_r == CNT_ONE);
    // The step always uses the latched mode and fill bits, so input changes mid-shift have no effect.
    assign step_s         = shift_step(op_r, reg_r, ls_r, rs_r);

    // State register: clr returns the controller to IDLE without waiting for a clock edge.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: set aborts the operation, and the last step returns to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        if (!set) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_shift_s) begin
                        state_nxt_s = ST_SHIFT;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (last_step_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Output/datapath logic: computes next register, flags, counter and latched request.
    always_comb begin
        reg_nxt_s  = reg_r;
        cout_nxt_s = cout_r;
        busy_nxt_s = busy_r;
        done_nxt_s = 1'b0;
        cnt_nxt_s  = cnt_r;
        op_nxt_s   = op_r;
        ls_nxt_s   = ls_r;
        rs_nxt_s   = rs_r;
        if (!set) begin
            // Abort to all ones; cout keeps the last bit it reported.
            reg_nxt_s  = {N{1'b1}};
            busy_nxt_s = 1'b0;
            done_nxt_s = 1'b0;
            cnt_nxt_s  = CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    busy_nxt_s = 1'b0;
                    if (!start) begin
                        done_nxt_s = 1'b0;
                    end else if (op == OP_LOAD) begin
                        reg_nxt_s  = Reg_in;
                        cout_nxt_s = 1'b0;
                        done_nxt_s = 1'b1;
                    end else if (accept_shift_s) begin
                        // Latch the request here; the first bit moves on the next edge.
                        cnt_nxt_s  = num_shift;
                        op_nxt_s   = op;
                        ls_nxt_s   = Ls;
                        rs_nxt_s   = Rs;
                        busy_nxt_s = 1'b1;
                        done_nxt_s = 1'b0;
                    end else begin
                        // Hold opcodes and zero-length shifts finish immediately.
                        done_nxt_s = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    reg_nxt_s  = step_s[N-1:0];
                    cout_nxt_s = step_s[N];
                    cnt_nxt_s  = cnt_r - CNT_ONE;
                    if (last_step_s) begin
                        busy_nxt_s = 1'b0;
                        done_nxt_s = 1'b1;
                    end else begin
                        busy_nxt_s = 1'b1;
                        done_nxt_s = 1'b0;
                    end
                end
                default: begin
                    busy_nxt_s = 1'b0;
                    done_nxt_s = 1'b0;
                    cnt_nxt_s  = CNT_ZERO;
                end
            endcase
        end
    end

    // Datapath registers: clr clears contents, flags and counter immediately.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            reg_r  <= {N{1'b0}};
            cout_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            cnt_r  <= CNT_ZERO;
            op_r   <= OP_HOLD;
            ls_r   <= 1'b0;
            rs_r   <= 1'b0;
        end else begin
            reg_r  <= reg_nxt_s;
            cout_r <= cout_nxt_s;
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
            cnt_r  <= cnt_nxt_s;
            op_r   <= op_nxt_s;
            ls_r   <= ls_nxt_s;
            rs_r   <= rs_nxt_s;
        end
    end

    assign Reg_out = reg_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign cout    = cout_r;
    // zero follows the register directly, so it stays valid during a shift.
    assign zero    = (reg_r == {N{1'b0}});

endmodule

// File: tb/tb_multi_mode_shifter.sv
// Testbench for multi_mode_shifter (N=8, SHW=4, so counts >= N are reachable).
// It runs a table of directed vectors, hand-written corner sequences, and random
// operations checked against an arithmetic reference model.

module tb_multi_mode_shifter;

    localparam int TN   = 8;
    localparam int MASK = 255;

    logic       clk = 1'b0;
    logic       clr;
    logic       set;
    logic       start;
    logic [2:0] op;
    logic [3:0] num_shift;
    logic       Ls;
    logic       Rs;
    logic [7:0] Reg_in;
    logic [7:0] Reg_out;
    logic       busy;
    logic       done;
    logic       cout;
    logic       zero;

    int checks = 0;
    int errors = 0;
    int m_reg  = 0;
    int m_cout = 0;

    multi_mode_shifter #(.N(8), .SHW(4)) dut (
        .clk(clk), .clr(clr), .set(set), .start(start), .op(op),
        .num_shift(num_shift), .Ls(Ls), .Rs(Rs), .Reg_in(Reg_in),
        .Reg_out(Reg_out), .busy(busy), .done(done), .cout(cout), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        int         n;
        bit         ls;
        bit         rs;
        logic [7:0] init;
        logic [7:0] exp_r;
        bit         exp_c;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_sh(input int o);
        return (o >= 2) && (o <= 6);
    endfunction

    // Computes the whole multi-bit operation in one step from the operation's definition.
    function automatic void ref_model(input int o, input int n, input int ls, input int rs,
                                      input int din, input int r, input int c,
                                      output int ro, output int co);
        int k;
        int sgn;
        ro = r;
        co = c;
        k = n % TN;
        sgn = (r >> (TN - 1)) & 1;
        if (o == 1) begin
            ro = din;
            co = 0;
        end else if (is_sh(o) && n > 0) begin
            case (o)
                2: begin
                    ro = ((r << n) | (ls != 0 ? ((1 << n) - 1) : 0)) & MASK;
                    co = (n <= TN) ? ((r >> (TN - n)) & 1) : ls;
                end
                3: begin
                    ro = (r >> n) | (rs != 0 ? (MASK & ~(MASK >> n)) : 0);
                    co = (n <= TN) ? ((r >> (n - 1)) & 1) : rs;
                end
                4: begin
                    ro = (r >> n) | (sgn != 0 ? (MASK & ~(MASK >> n)) : 0);
                    co = (n <= TN) ? ((r >> (n - 1)) & 1) : sgn;
                end
                5: begin
                    ro = ((r << k) | (r >> (TN - k))) & MASK;
                    co = (r >> ((TN - k) % TN)) & 1;
                end
                default: begin
                    ro = ((r >> k) | (r << (TN - k))) & MASK;
                    co = (r >> ((n - 1) % TN)) & 1;
                end
            endcase
        end
    endfunction

    // Issues one request and waits for done; during the operation, unrelated inputs are scrambled.
    task automatic run_op(input logic [2:0] o, input int n, input bit ls, input bit rs,
                          input logic [7:0] din, input bit chain,
                          output int lat, output int bc, output bit to);
        if (!chain) @(negedge clk);
        start = 1'b1; op = o; num_shift = 4'(n); Ls = ls; Rs = rs; Reg_in = din;
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); num_shift = 4'($urandom);
        Ls = 1'($urandom); Rs = 1'($urandom); Reg_in = 8'($urandom);
        lat = 1;
        bc = 0;
        while (!done && lat < 40) begin
            if (busy) bc++;
            @(negedge clk);
            lat++;
        end
        to = !done;
    endtask

    task automatic do_check(input string nm, input logic [2:0] o, input int n, input bit ls,
                            input bit rs, input logic [7:0] din, input bit chain,
                            input logic [7:0] er, input bit ec);
        int lat;
        int bc;
        bit to;
        int eb;
        run_op(o, n, ls, rs, din, chain, lat, bc, to);
        eb = (is_sh(int'(o)) && n > 0) ? n : 0;
        check({nm, "_timeout"}, 32'(to), 32'd0);
        check({nm, "_reg"}, 32'(Reg_out), 32'(er));
        check({nm, "_cout"}, 32'(cout), 32'(ec));
        check({nm, "_zero"}, 32'(zero), 32'(er == 8'h00));
        check({nm, "_busy_cycles"}, 32'(bc), 32'(eb));
        check({nm, "_latency"}, 32'(lat), 32'(eb + 1));
        m_reg = int'(er);
        m_cout = int'(ec);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int bc;
        bit to;
        int dcnt;
        int ro;
        int co;
        int o;
        int n;
        bit ls;
        bit rs;
        logic [7:0] init;

        vecs[0]  = '{3'b010, 3,  1'b0, 1'b0, 8'hA5, 8'h28, 1'b1};
        vecs[1]  = '{3'b100, 2,  1'b0, 1'b0, 8'h96, 8'hE5, 1'b1};
        vecs[2]  = '{3'b110, 4,  1'b0, 1'b0, 8'h3C, 8'hC3, 1'b1};
        vecs[3]  = '{3'b011, 7,  1'b0, 1'b0, 8'h80, 8'h01, 1'b0};
        vecs[4]  = '{3'b011, 7,  1'b0, 1'b0, 8'h01, 8'h00, 1'b0};
        vecs[5]  = '{3'b101, 4,  1'b0, 1'b0, 8'hF0, 8'h0F, 1'b1};
        vecs[6]  = '{3'b010, 7,  1'b1, 1'b0, 8'h81, 8'hFF, 1'b0};
        vecs[7]  = '{3'b110, 0,  1'b0, 1'b0, 8'h55, 8'h55, 1'b0};
        vecs[8]  = '{3'b010, 12, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b1};
        vecs[9]  = '{3'b101, 10, 1'b0, 1'b0, 8'h81, 8'h06, 1'b0};
        vecs[10] = '{3'b100, 9,  1'b0, 1'b0, 8'h80, 8'hFF, 1'b1};
        vecs[11] = '{3'b011, 15, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0};
        vecs[12] = '{3'b000, 0,  1'b0, 1'b0, 8'h3C, 8'h3C, 1'b0};
        vecs[13] = '{3'b111, 5,  1'b0, 1'b0, 8'h3C, 8'h3C, 1'b0};
        vecs[14] = '{3'b110, 9,  1'b0, 1'b0, 8'h01, 8'h80, 1'b1};
        vecs[15] = '{3'b011, 3,  1'b0, 1'b1, 8'h00, 8'hE0, 1'b0};

        clr = 1'b0; set = 1'b1; start = 1'b0; op = 3'b000; num_shift = 4'd0;
        Ls = 1'b0; Rs = 1'b0; Reg_in = 8'h00;
        #12;
        check("reset_reg", 32'(Reg_out), 32'h00);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        check("reset_zero", 32'(zero), 32'd1);
        @(negedge clk);
        clr = 1'b1;

        // Directed table: load the initial value, then run the operation.
        for (int i = 0; i < 16; i++) begin
            do_check($sformatf("vec%0d_load", i), 3'b001, 0, 1'b0, 1'b0, vecs[i].init, 1'b0,
                     vecs[i].init, 1'b0);
            do_check($sformatf("vec%0d_op", i), vecs[i].op, vecs[i].n, vecs[i].ls, vecs[i].rs,
                     8'h00, 1'b0, vecs[i].exp_r, vecs[i].exp_c);
        end

        // clr asserted mid-shift must clear everything without a clock edge.
        do_check("clr_load", 3'b001, 0, 1'b0, 1'b0, 8'hA5, 1'b0, 8'hA5, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 3'b010; num_shift = 4'd5; Ls = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("clr_pre_busy", 32'(busy), 32'd1);
        #2;
        clr = 1'b0;
        #1;
        check("clr_async_reg", 32'(Reg_out), 32'h00);
        check("clr_async_busy", 32'(busy), 32'd0);
        check("clr_async_done", 32'(done), 32'd0);
        check("clr_async_cout", 32'(cout), 32'd0);
        @(negedge clk);
        clr = 1'b1;

        // Starts issued while busy must be ignored.
        do_check("ign_load", 3'b001, 0, 1'b0, 1'b0, 8'hA5, 1'b0, 8'hA5, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 3'b010; num_shift = 4'd3; Ls = 1'b0;
        @(negedge clk);
        op = 3'b001; Reg_in = 8'h00; num_shift = 4'd1;
        lat = 1;
        dcnt = 0;
        while (!done && lat < 40) begin
            if (lat >= 2) start = 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("ign_timeout", 32'(done), 32'd1);
        check("ign_reg", 32'(Reg_out), 32'h28);
        check("ign_cout", 32'(cout), 32'd1);
        check("ign_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("ign_no_extra_done", 32'(dcnt), 32'd0);

        // A set pulse during the second shifting cycle aborts to FF without done.
        do_check("set_load", 3'b001, 0, 1'b0, 1'b0, 8'h01, 1'b0, 8'h01, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 3'b010; num_shift = 4'd5; Ls = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("set_mid_reg", 32'(Reg_out), 32'h02);
        set = 1'b0;
        @(negedge clk);
        set = 1'b1;
        check("set_reg", 32'(Reg_out), 32'hFF);
        check("set_busy", 32'(busy), 32'd0);
        check("set_done", 32'(done), 32'd0);
        check("set_cout", 32'(cout), 32'd0);
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        check("set_no_done_after", 32'(dcnt), 32'd0);
        check("set_reg_held", 32'(Reg_out), 32'hFF);

        // Back-to-back requests, each issued on the previous done cycle.
        do_check("b2b_load", 3'b001, 0, 1'b0, 1'b0, 8'h0F, 1'b0, 8'h0F, 1'b0);
        do_check("b2b_shl0", 3'b010, 0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h0F, 1'b0);
        do_check("b2b_rol0", 3'b101, 0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h0F, 1'b0);
        do_check("b2b_load2", 3'b001, 0, 1'b0, 1'b0, 8'h3C, 1'b1, 8'h3C, 1'b0);
        do_check("b2b_shr2", 3'b011, 2, 1'b0, 1'b1, 8'h00, 1'b1, 8'hCF, 1'b0);
        do_check("b2b_ror3", 3'b110, 3, 1'b0, 1'b0, 8'h00, 1'b1, 8'hF9, 1'b1);

        // Random operations checked against the reference model.
        for (int i = 0; i < 80; i++) begin
            init = 8'($urandom);
            o = int'($urandom_range(0, 7));
            n = int'($urandom_range(0, 15));
            ls = 1'($urandom);
            rs = 1'($urandom);
            if (($urandom & 3) != 0) begin
                do_check($sformatf("rnd%0d_load", i), 3'b001, 0, 1'b0, 1'b0, init, 1'b0,
                         init, 1'b0);
            end
            ref_model(o, n, int'(ls), int'(rs), int'(init), m_reg, m_cout, ro, co);
            do_check($sformatf("rnd%0d_op%0d_n%0d", i, o, n), 3'(o), n, ls, rs, init,
                     1'($urandom), 8'(ro), 1'(co));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
